// File: rtl/snake_pkg.sv
// Shared VGA timing package.
// Holds the default 640x480@60 timing constants, the derived line/frame
// totals and the coordinate widths, so the pixel renderer and the timing
// generator agree on geometry without duplicating numbers.
package snake_pkg;

  // Default horizontal timing, in pixel clocks.
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;

  // Default vertical timing, in lines.
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  // Derived totals: 800 clocks per line, 525 lines per frame.
  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Counter and coordinate widths.
  localparam int CNT_W = 10;
  localparam int X_W   = 10;
  localparam int Y_W   = 9;

  typedef logic [CNT_W-1:0] cnt_t;

  // Inclusive range test used for the sync-pulse windows.
  function automatic logic in_range(input cnt_t v, input cnt_t lo, input cnt_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA timing generator.
// Free-running horizontal/vertical counters driven by the pixel clock, with
// all outputs registered from the counter values present before each edge
// (fixed one-clock latency from counter to output).
//
// Ports:
//   clk_25M     in   pixel clock
//   rst_n       in   asynchronous active-low reset
//   hsync       out  horizontal sync, active-low
//   vsync       out  vertical sync, active-low
//   video_on    out  high while the current pixel is visible
//   x [9:0]     out  visible column, 0 when blanked
//   y [8:0]     out  visible row, 0 when blanked
//   frame_start out  one-clock pulse at pixel (0,0)
//   line_end    out  one-clock pulse on the last clock of every line
module vga_timing
  import snake_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic           clk_25M,
  input  logic           rst_n,
  output logic           hsync,
  output logic           vsync,
  output logic           video_on,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           frame_start,
  output logic           line_end
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_VIS  = cnt_t'(H_VISIBLE);
  localparam cnt_t V_VIS  = cnt_t'(V_VISIBLE);
  localparam cnt_t HS_LO  = cnt_t'(H_VISIBLE + H_FRONT);
  localparam cnt_t HS_HI  = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam cnt_t VS_LO  = cnt_t'(V_VISIBLE + V_FRONT);
  localparam cnt_t VS_HI  = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  cnt_t           h_cnt_q, h_cnt_d;
  cnt_t           v_cnt_q, v_cnt_d;
  logic           h_wrap_s;

  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           video_on_q, video_on_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           frame_start_q, frame_start_d;
  logic           line_end_q, line_end_d;

  // Counter next state: wrap by explicit compare, vertical steps only on horizontal wrap.
  always_comb begin
    h_wrap_s = (h_cnt_q == H_LAST);
    if (h_wrap_s) begin
      h_cnt_d = 10'd0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = 10'd0;
      end else begin
        v_cnt_d = v_cnt_q + 10'd1;
      end
    end else begin
      h_cnt_d = h_cnt_q + 10'd1;
      v_cnt_d = v_cnt_q;
    end
  end

  // Output decode from the current counter values; registered below.
  always_comb begin
    video_on_d    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    hsync_d       = ~in_range(h_cnt_q, HS_LO, HS_HI);
    vsync_d       = ~in_range(v_cnt_q, VS_LO, VS_HI);
    frame_start_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    line_end_d    = h_wrap_s;
    if (video_on_d) begin
      x_d = h_cnt_q;
      y_d = v_cnt_q[Y_W-1:0];
    end else begin
      x_d = 10'd0;
      y_d = 9'd0;
    end
  end

  // Counter and output registers; reset restarts the raster at (0,0) with syncs idle.
  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      x_q           <= 10'd0;
      y_q           <= 9'd0;
      frame_start_q <= 1'b0;
      line_end_q    <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      line_end_q    <= line_end_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = frame_start_q;
  assign line_end    = line_end_q;

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing.
// Instance A uses the default 640x480 timing and is checked over the first
// lines; instance B uses a tiny raster (25 clocks x 14 lines) so whole frames
// and a mid-frame reset fit in a short run.
module tb_vga_timing;

  logic clk_25M = 1'b0;
  always #20 clk_25M = ~clk_25M;

  logic       rst_a_n, rst_b_n;
  logic       hs_a, vs_a, von_a, fs_a, le_a;
  logic [9:0] x_a;
  logic [8:0] y_a;
  logic       hs_b, vs_b, von_b, fs_b, le_b;
  logic [9:0] x_b;
  logic [8:0] y_b;

  vga_timing u_dut_a (
    .clk_25M(clk_25M), .rst_n(rst_a_n), .hsync(hs_a), .vsync(vs_a),
    .video_on(von_a), .x(x_a), .y(y_a), .frame_start(fs_a), .line_end(le_a)
  );

  vga_timing #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
    .V_VISIBLE(8),  .V_FRONT(1), .V_SYNC(2), .V_BACK(3)
  ) u_dut_b (
    .clk_25M(clk_25M), .rst_n(rst_b_n), .hsync(hs_b), .vsync(vs_b),
    .video_on(von_b), .x(x_b), .y(y_b), .frame_start(fs_b), .line_end(le_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  initial begin
    int   von_first, hs_fall1, hs_fall2, hs_low, von_cnt, le_cnt, le_first;
    int   fs_cnt, fs_second, zero_bad, vs_low, vs_first, max_x, max_y, le_bad;
    logic hs_prev;

    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    #1;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (3) @(negedge clk_25M);

    // Reset values while rst_n is low
    check("rst_hsync",    32'(hs_a),  32'd1);
    check("rst_vsync",    32'(vs_a),  32'd1);
    check("rst_video_on", 32'(von_a), 32'd0);
    check("rst_x",        32'(x_a),   32'd0);
    check("rst_y",        32'(y_a),   32'd0);
    check("rst_fs",       32'(fs_a),  32'd0);
    check("rst_le",       32'(le_a),  32'd0);
    check("rst_b_hsync",  32'(hs_b),  32'd1);

    // ---------------- Default timing, first lines ----------------
    rst_a_n   = 1'b1;
    von_first = -1; hs_fall1 = -1; hs_fall2 = -1; le_first = -1;
    hs_low = 0; von_cnt = 0; le_cnt = 0; fs_cnt = 0; zero_bad = 0; vs_low = 0;
    hs_prev = 1'b1;
    for (int k = 0; k < 1800; k++) begin
      @(negedge clk_25M);
      if (k == 0) begin
        check("a_first_fs",  32'(fs_a),  32'd1);
        check("a_first_von", 32'(von_a), 32'd1);
        check("a_first_x",   32'(x_a),   32'd0);
        check("a_first_y",   32'(y_a),   32'd0);
      end
      if (von_a && von_first < 0) von_first = k;
      if (!hs_a && k < 800) hs_low++;
      if (!hs_a && hs_prev) begin
        if (hs_fall1 < 0) hs_fall1 = k;
        else if (hs_fall2 < 0) hs_fall2 = k;
      end
      hs_prev = hs_a;
      if (von_a && k < 800) von_cnt++;
      if (le_a) begin
        le_cnt++;
        if (le_first < 0) le_first = k;
      end
      if (fs_a) fs_cnt++;
      if (!von_a && (x_a != 10'd0 || y_a != 9'd0)) zero_bad++;
      if (!vs_a) vs_low++;
      if (k == 639) check("a_x_last", 32'(x_a), 32'd639);
      if (k == 640) check("a_x_blank", 32'(x_a), 32'd0);
      if (k == 801) begin
        check("a_line1_x", 32'(x_a), 32'd1);
        check("a_line1_y", 32'(y_a), 32'd1);
      end
    end
    check("a_hsync_low_clocks",  32'(hs_low),                    32'd96);
    check("a_hsync_fall_incl",   32'(hs_fall1 - von_first + 1),  32'd657);
    check("a_hsync_period",      32'(hs_fall2 - hs_fall1),       32'd800);
    check("a_video_on_line0",    32'(von_cnt),                   32'd640);
    check("a_line_end_count",    32'(le_cnt),                    32'd2);
    check("a_line_end_first",    32'(le_first),                  32'd799);
    check("a_frame_start_count", 32'(fs_cnt),                    32'd1);
    check("a_blank_xy_zero",     32'(zero_bad),                  32'd0);
    check("a_vsync_idle",        32'(vs_low),                    32'd0);

    // ---------------- Small raster, full frames ----------------
    rst_b_n  = 1'b1;
    fs_cnt = 0; fs_second = -1; vs_low = 0; vs_first = -1; von_cnt = 0;
    max_x = 0; max_y = 0; zero_bad = 0; le_cnt = 0; le_bad = 0; hs_low = 0;
    for (int k = 0; k <= 700; k++) begin
      @(negedge clk_25M);
      if (fs_b) begin
        fs_cnt++;
        if (k > 0 && fs_second < 0) fs_second = k;
      end
      if (k < 350) begin
        if (!vs_b) begin
          vs_low++;
          if (vs_first < 0) vs_first = k;
        end
        if (von_b) von_cnt++;
        if (le_b) le_cnt++;
        if (!hs_b) hs_low++;
      end
      if (von_b && int'(x_b) > max_x) max_x = int'(x_b);
      if (von_b && int'(y_b) > max_y) max_y = int'(y_b);
      if (!von_b && (x_b != 10'd0 || y_b != 9'd0)) zero_bad++;
      if (le_b != ((k % 25) == 24)) le_bad++;
    end
    check("b_frame_start_count",  32'(fs_cnt),    32'd3);
    check("b_frame_period",       32'(fs_second), 32'd350);
    check("b_vsync_low_clocks",   32'(vs_low),    32'd50);
    check("b_vsync_start",        32'(vs_first),  32'd225);
    check("b_video_on_clocks",    32'(von_cnt),   32'd128);
    check("b_x_max",              32'(max_x),     32'd15);
    check("b_y_max",              32'(max_y),     32'd7);
    check("b_blank_xy_zero",      32'(zero_bad),  32'd0);
    check("b_line_end_count",     32'(le_cnt),    32'd14);
    check("b_line_end_position",  32'(le_bad),    32'd0);
    check("b_hsync_low_clocks",   32'(hs_low),    32'd42);

    // ---------------- Mid-frame asynchronous reset inside hsync ----------------
    rst_b_n = 1'b0;
    @(negedge clk_25M);
    rst_b_n = 1'b1;
    for (int k = 0; k <= 144; k++) @(negedge clk_25M);
    // Sample 144 is h=19, v=5: inside the hsync window
    check("b_pre_rst_hsync", 32'(hs_b), 32'd0);
    check("b_pre_rst_y",     32'(y_b),  32'd0);
    #5;
    rst_b_n = 1'b0;
    #1;
    check("b_async_hsync", 32'(hs_b),  32'd1);
    check("b_async_vsync", 32'(vs_b),  32'd1);
    check("b_async_von",   32'(von_b), 32'd0);
    check("b_async_le",    32'(le_b),  32'd0);
    repeat (3) @(negedge clk_25M);
    check("b_held_hsync", 32'(hs_b), 32'd1);
    check("b_held_fs",    32'(fs_b), 32'd0);
    rst_b_n = 1'b1;
    @(negedge clk_25M);
    check("b_restart_fs",    32'(fs_b),  32'd1);
    check("b_restart_von",   32'(von_b), 32'd1);
    check("b_restart_x",     32'(x_b),   32'd0);
    check("b_restart_y",     32'(y_b),   32'd0);
    check("b_restart_hsync", 32'(hs_b),  32'd1);
    @(negedge clk_25M);
    check("b_restart_x1",    32'(x_b),   32'd1);
    check("b_restart_fs_off",32'(fs_b),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
